// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs field-level MIPS instruction commands into 32-bit words and
//            streams them into instruction memory at consecutive addresses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_kind,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [5:0]        cmd_funct,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    input  logic              cmd_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] C_LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    localparam logic [2:0] C_K_RTYPE = 3'd0;
    localparam logic [2:0] C_K_LW    = 3'd1;
    localparam logic [2:0] C_K_SW    = 3'd2;
    localparam logic [2:0] C_K_BEQ   = 3'd3;
    localparam logic [2:0] C_K_ADDI  = 3'd4;
    localparam logic [2:0] C_K_J     = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W:0]     r_count;

    logic                w_accept;
    logic                w_legal;
    logic                w_full;
    logic                w_start_ok;
    logic [31:0]         w_word;

    // The write pointer always equals the session word count, so one register
    // serves both roles.
    assign w_accept   = cmd_valid & (r_state == S_LOAD);
    assign w_legal    = (cmd_kind <= C_K_J);
    assign w_full     = (r_count == C_LAST_ADDR);
    assign w_start_ok = start & (r_state != S_LOAD);

    always_comb begin
        w_word = 32'd0;
        case (cmd_kind)
            C_K_RTYPE: w_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b00000, cmd_funct};
            C_K_LW:    w_word = {6'b100011, cmd_rs, cmd_rt, cmd_imm};
            C_K_SW:    w_word = {6'b101011, cmd_rs, cmd_rt, cmd_imm};
            C_K_BEQ:   w_word = {6'b000100, cmd_rs, cmd_rt, cmd_imm};
            C_K_ADDI:  w_word = {6'b001000, cmd_rs, cmd_rt, cmd_imm};
            C_K_J:     w_word = {6'b000010, cmd_target};
            default:   w_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept && (cmd_last || (w_legal && w_full))) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            r_busy <= (w_next == S_LOAD);
            r_done <= (w_next == S_DONE);
            r_we   <= w_accept & w_legal;
            if (w_start_ok) begin
                r_count <= '0;
                r_err   <= 1'b0;
            end else if (w_accept) begin
                if (w_legal) begin
                    r_addr  <= r_count[ADDR_W-1:0];
                    r_wdata <= w_word;
                    r_count <= r_count + 1'b1;
                    // Filling the last slot without cmd_last means commands were lost.
                    if (w_full && !cmd_last) begin
                        r_err <= 1'b1;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready  = (r_state == S_LOAD);
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign count      = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Self-checking bench for instr_encoder; drives a 64-word and a
//            4-word instance with the same commands against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cmd_valid;
    logic [2:0]  cmd_kind;
    logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
    logic [5:0]  cmd_funct;
    logic [15:0] cmd_imm;
    logic [25:0] cmd_target;
    logic        cmd_last;

    logic        rdy6, we6, busy6, done6, err6;
    logic [5:0]  addr6;
    logic [31:0] wdata6;
    logic [6:0]  cnt6;
    logic        rdy2, we2, busy2, done2, err2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic [2:0]  cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, index 0 = 64-word instance, 1 = 4-word instance
    int          depth [2] = '{64, 4};
    bit          m_load [2];
    bit          m_done [2];
    bit          m_err  [2];
    int          m_cnt  [2];
    bit          m_we   [2];
    int          m_addr [2];
    logic [31:0] m_data [2];
    logic [31:0] mem6 [64];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(6)) u6 (
        .clk(clk), .reset(reset), .start(start), .cmd_valid(cmd_valid), .cmd_ready(rdy6),
        .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_funct(cmd_funct), .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
        .imem_we(we6), .imem_addr(addr6), .imem_wdata(wdata6),
        .busy(busy6), .done(done6), .err(err6), .count(cnt6)
    );

    instr_encoder #(.ADDR_W(2)) u2 (
        .clk(clk), .reset(reset), .start(start), .cmd_valid(cmd_valid), .cmd_ready(rdy2),
        .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_funct(cmd_funct), .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
        .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
        .busy(busy2), .done(done2), .err(err2), .count(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] encode(input logic [2:0] k);
        case (k)
            3'd0:    return {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'd0, cmd_funct};
            3'd1:    return {6'b100011, cmd_rs, cmd_rt, cmd_imm};
            3'd2:    return {6'b101011, cmd_rs, cmd_rt, cmd_imm};
            3'd3:    return {6'b000100, cmd_rs, cmd_rt, cmd_imm};
            3'd4:    return {6'b001000, cmd_rs, cmd_rt, cmd_imm};
            default: return {6'b000010, cmd_target};
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_load[d] = 0; m_done[d] = 0; m_err[d] = 0; m_cnt[d] = 0; m_we[d] = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            m_we[d] = 0;
            if (m_load[d]) begin
                if (cmd_valid) begin
                    if (cmd_kind < 6) begin
                        m_we[d]   = 1;
                        m_addr[d] = m_cnt[d];
                        m_data[d] = encode(cmd_kind);
                        m_cnt[d]++;
                    end else begin
                        m_err[d] = 1;
                    end
                    if (cmd_last) begin
                        m_load[d] = 0; m_done[d] = 1;
                    end else if (cmd_kind < 6 && m_cnt[d] == depth[d]) begin
                        m_load[d] = 0; m_done[d] = 1; m_err[d] = 1;
                    end
                end
            end else if (start) begin
                m_load[d] = 1; m_done[d] = 0; m_cnt[d] = 0; m_err[d] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("we6",    {31'd0, we6},    {31'd0, m_we[0]});
        chk("busy6",  {31'd0, busy6},  {31'd0, m_load[0]});
        chk("done6",  {31'd0, done6},  {31'd0, m_done[0]});
        chk("err6",   {31'd0, err6},   {31'd0, m_err[0]});
        chk("count6", {25'd0, cnt6},   m_cnt[0]);
        chk("we2",    {31'd0, we2},    {31'd0, m_we[1]});
        chk("busy2",  {31'd0, busy2},  {31'd0, m_load[1]});
        chk("done2",  {31'd0, done2},  {31'd0, m_done[1]});
        chk("err2",   {31'd0, err2},   {31'd0, m_err[1]});
        chk("count2", {29'd0, cnt2},   m_cnt[1]);
        if (m_we[0]) begin
            chk("addr6",  {26'd0, addr6}, m_addr[0]);
            chk("wdata6", wdata6, m_data[0]);
        end
        if (m_we[1]) begin
            chk("addr2",  {30'd0, addr2}, m_addr[1]);
            chk("wdata2", wdata2, m_data[1]);
        end
        if (we6) mem6[addr6] = wdata6;
    endtask

    // One clock: check combinational ready, take the edge, then check registers.
    task automatic step();
        chk("ready6", {31'd0, rdy6}, {31'd0, m_load[0]});
        chk("ready2", {31'd0, rdy2}, {31'd0, m_load[1]});
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last);
        cmd_valid = 1; cmd_kind = k; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
        cmd_funct = fn; cmd_imm = imm; cmd_target = tgt; cmd_last = last;
        step();
        cmd_valid = 0; cmd_last = 0;
    endtask

    task automatic begin_session();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic idle(input int n);
        cmd_valid = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1; start = 0; cmd_valid = 0; cmd_kind = 0; cmd_rs = 0; cmd_rt = 0;
        cmd_rd = 0; cmd_funct = 0; cmd_imm = 0; cmd_target = 0; cmd_last = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",    {31'd0, we6}, 32'd0);
        chk("rst_addr",  {26'd0, addr6}, 32'd0);
        chk("rst_wdata", wdata6, 32'd0);
        chk("rst_ready", {31'd0, rdy6}, 32'd0);
        check_outputs();
        reset = 0;
        idle(1);

        // Basic load
        begin_session();
        send(3'd4, 5'd0, 5'd8, 5'd0, 6'h00, 16'd5, 26'd0, 1'b0);
        send(3'd0, 5'd8, 5'd8, 5'd9, 6'h20, 16'd0, 26'd0, 1'b0);
        send(3'd5, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 26'd0, 1'b1);
        idle(2);
        chk("basic_w0", mem6[0], 32'h20080005);
        chk("basic_w1", mem6[1], 32'h01084820);
        chk("basic_w2", mem6[2], 32'h08000000);
        chk("basic_cnt", {25'd0, cnt6}, 32'd3);
        chk("basic_done", {31'd0, done6}, 32'd1);

        // Memory encodings
        begin_session();
        send(3'd1, 5'd0, 5'd2, 5'd0, 6'h00, 16'h0050, 26'd0, 1'b0);
        send(3'd2, 5'd0, 5'd2, 5'd0, 6'h00, 16'h0054, 26'd0, 1'b0);
        send(3'd3, 5'd2, 5'd2, 5'd0, 6'h00, 16'hFFFE, 26'd0, 1'b1);
        idle(1);
        chk("mem_w0", mem6[0], 32'h8C020050);
        chk("mem_w1", mem6[1], 32'hAC020054);
        chk("mem_w2", mem6[2], 32'h1042FFFE);

        // Illegal kind between two ADDIs
        begin_session();
        send(3'd4, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0011, 26'd0, 1'b0);
        send(3'd6, 5'd3, 5'd4, 5'd5, 6'h3F, 16'hAAAA, 26'h3FFFFFF, 1'b0);
        send(3'd4, 5'd1, 5'd3, 5'd0, 6'h00, 16'h0022, 26'd0, 1'b1);
        idle(3);
        chk("ill_err", {31'd0, err6}, 32'd1);
        chk("ill_cnt", {25'd0, cnt6}, 32'd2);
        begin_session();
        chk("ill_clear", {31'd0, err6}, 32'd0);

        // Overflow on the 4-word instance; the 64-word one keeps loading
        for (int i = 0; i < 5; i++)
            send(3'd4, 5'd0, 5'(i), 5'd0, 6'h00, 16'(i + 1), 26'd0, 1'b0);
        chk("ovf_done2", {31'd0, done2}, 32'd1);
        chk("ovf_err2",  {31'd0, err2},  32'd1);
        chk("ovf_cnt2",  {29'd0, cnt2},  32'd4);
        send(3'd5, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 26'h0000040, 1'b1);
        idle(1);

        // Backpressure with start ignored during LOAD, then restart from DONE
        begin_session();
        send(3'd4, 5'd7, 5'd7, 5'd0, 6'h00, 16'h1234, 26'd0, 1'b0);
        start = 1;
        idle(2);
        start = 0;
        send(3'd0, 5'd1, 5'd2, 5'd3, 6'h22, 16'd0, 26'd0, 1'b1);
        idle(1);
        begin_session();
        chk("restart_cnt", {25'd0, cnt6}, 32'd0);
        send(3'd4, 5'd0, 5'd1, 5'd0, 6'h00, 16'h0001, 26'd0, 1'b1);
        idle(1);

        // Randomized sessions, start occasionally toggled
        for (int s = 0; s < 8; s++) begin
            int n;
            begin_session();
            n = $urandom_range(3, 12);
            for (int i = 0; i < n; i++) begin
                cmd_valid  = ($urandom_range(0, 3) != 0);
                cmd_kind   = 3'($urandom_range(0, 7));
                cmd_rs     = 5'($urandom);
                cmd_rt     = 5'($urandom);
                cmd_rd     = 5'($urandom);
                cmd_funct  = 6'($urandom);
                cmd_imm    = 16'($urandom);
                cmd_target = 26'($urandom);
                cmd_last   = (i == n - 1);
                start      = ($urandom_range(0, 5) == 0);
                step();
            end
            start = 0; cmd_last = 0;
            idle(2);
        end

        // Asynchronous reset in the cycle right after an accept
        begin_session();
        send(3'd4, 5'd0, 5'd9, 5'd0, 6'h00, 16'h00AA, 26'd0, 1'b0);
        #2 reset = 1;
        #1;
        chk("arst_we",    {31'd0, we6},  32'd0);
        chk("arst_ready", {31'd0, rdy6}, 32'd0);
        chk("arst_busy",  {31'd0, busy6}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        reset = 0;
        cmd_valid = 1;
        for (int i = 0; i < 3; i++) step();
        cmd_valid = 0;
        chk("arst_cnt", {25'd0, cnt6}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
